// File: rtl/sdf_r2_stage_32.sv
// ---------------------------------------------------------------------------
// sdf_r2_stage_32
//
// One radix-2 single-path delay-feedback (SDF) butterfly stage of a pipelined
// FFT, spanning 32 points. A 16-entry complex delay line holds the first half
// of each frame. The stage then emits the 16 butterfly sums followed by the
// 16 twiddled differences. The phase (`state`) and the Q8 twiddle (`w_r`,
// `w_i`) come cycle-by-cycle from the twiddle ROM that shares `in_valid`.
//
// Ports
//   clk              : clock, rising edge
//   rst              : synchronous active-high reset, priority over all inputs
//   in_valid         : din_r/din_i carry a new sample
//   din_r, din_i     : input sample (signed DW)
//   state            : 0 fill, 1 butterfly-add, 2 twiddle-multiply (3 = fill)
//   w_r, w_i         : twiddle (signed TW, Q8), used when state = 2
//   dout_r, dout_i   : registered output sample (signed DW)
//   dout_valid       : dout_r/dout_i valid
//   dout_last        : marks the 32nd output of each frame
//
// Stream semantics: there is no back-pressure. An output sample is
// transferred on every cycle where dout_valid is high. The operation selected
// by `state` in cycle t is visible on the outputs one edge later. dout_last
// is only ever high together with dout_valid.
// ---------------------------------------------------------------------------
module sdf_r2_stage_32 #(
    parameter int DW    = 24,
    parameter int TW    = 24,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] din_r,
    input  logic [DW-1:0] din_i,
    input  logic [1:0]    state,
    input  logic [TW-1:0] w_r,
    input  logic [TW-1:0] w_i,
    output logic [DW-1:0] dout_r,
    output logic [DW-1:0] dout_i,
    output logic          dout_valid,
    output logic          dout_last
);

    // Phase encodings driven by the twiddle ROM.
    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;

    localparam int PW = DW + TW;   // full product width
    localparam int CW = 5;         // output counter width (32 outputs/frame)
    localparam logic [CW-1:0] CNT_LAST = 5'd31;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [DW-1:0] dl_r_q [DEPTH];
    logic [DW-1:0] dl_i_q [DEPTH];
    logic [DW-1:0] dout_r_q, dout_r_d;
    logic [DW-1:0] dout_i_q, dout_i_d;
    logic          valid_q,  valid_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    // Delay-line control
    logic          shift_en;
    logic [DW-1:0] push_r_d;
    logic [DW-1:0] push_i_d;

    // Oldest entry of the delay line (entry 0 receives each push).
    logic [DW-1:0] head_r;
    logic [DW-1:0] head_i;

    assign head_r = dl_r_q[DEPTH-1];
    assign head_i = dl_i_q[DEPTH-1];

    // ------------------------------------------------------------------
    // Butterfly add/sub: DW-bit modular arithmetic, no growth bit.
    // ------------------------------------------------------------------
    logic [DW-1:0] sum_r, sum_i;
    logic [DW-1:0] dif_r, dif_i;

    assign sum_r = head_r + din_r;
    assign sum_i = head_i + din_i;
    assign dif_r = head_r - din_r;
    assign dif_i = head_i - din_i;

    // ------------------------------------------------------------------
    // Complex twiddle multiply: head * (w_r + j*w_i).
    // Operands are sign-extended to the full product width so an unsigned
    // PW-bit multiply yields the exact signed product in PW bits.
    // ------------------------------------------------------------------
    logic [PW-1:0] hr_x, hi_x, wr_x, wi_x;
    logic [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW:0] pr_full, pi_full;
    logic [DW-1:0] prod_r, prod_i;

    assign hr_x = {{TW{head_r[DW-1]}}, head_r};
    assign hi_x = {{TW{head_i[DW-1]}}, head_i};
    assign wr_x = {{DW{w_r[TW-1]}}, w_r};
    assign wi_x = {{DW{w_i[TW-1]}}, w_i};

    assign p_rr = hr_x * wr_x;
    assign p_ii = hi_x * wi_x;
    assign p_ri = hr_x * wi_x;
    assign p_ir = hi_x * wr_x;

    // One guard bit so the sum of two full products cannot overflow.
    assign pr_full = $signed({p_rr[PW-1], p_rr}) - $signed({p_ii[PW-1], p_ii});
    assign pi_full = $signed({p_ri[PW-1], p_ri}) + $signed({p_ir[PW-1], p_ir});

    // Q8 rescale: arithmetic shift (floor) then keep the low DW bits.
    assign prod_r = DW'(pr_full >>> 8);
    assign prod_i = DW'(pi_full >>> 8);

    // ------------------------------------------------------------------
    // Phase decode: next output, delay-line push value and shift enable.
    // ------------------------------------------------------------------
    always_comb begin
        shift_en = in_valid;
        push_r_d = din_r;
        push_i_d = din_i;
        dout_r_d = dout_r_q;
        dout_i_d = dout_i_q;
        valid_d  = 1'b0;
        case (state)
            ST_ADD: begin
                // The ROM advances every cycle in this phase, so the line
                // shifts regardless of in_valid.
                shift_en = 1'b1;
                push_r_d = dif_r;
                push_i_d = dif_i;
                dout_r_d = sum_r;
                dout_i_d = sum_i;
                valid_d  = 1'b1;
            end
            ST_MUL: begin
                // The incoming samples pre-fill the next frame's first half.
                shift_en = 1'b1;
                dout_r_d = prod_r;
                dout_i_d = prod_i;
                valid_d  = 1'b1;
            end
            ST_FILL: begin
                // Pure fill: push on in_valid, no output.
            end
            default: begin
                // Encoding 3 behaves as fill.
            end
        endcase
    end

    // Output counter advances once per emitted sample and wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dl_r_q[i] <= '0;
                dl_i_q[i] <= '0;
            end
        end else if (shift_en) begin
            dl_r_q[0] <= push_r_d;
            dl_i_q[0] <= push_i_d;
            for (int i = 1; i < DEPTH; i++) begin
                dl_r_q[i] <= dl_r_q[i-1];
                dl_i_q[i] <= dl_i_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r_q <= '0;
            dout_i_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            dout_r_q <= dout_r_d;
            dout_i_q <= dout_i_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout_r     = dout_r_q;
    assign dout_i     = dout_i_q;
    assign dout_valid = valid_q;
    assign dout_last  = valid_q && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_sdf_r2_stage_32.sv
// ---------------------------------------------------------------------------
// tb_sdf_r2_stage_32
//
// Directed bench for sdf_r2_stage_32. Each frame's expected outputs are
// queued before its stimulus is driven. A negedge monitor pops one entry per
// valid output and compares {dout_last, dout_r, dout_i}. The expected values
// come from a frame-level arithmetic model (X[k] = x[k] + x[k+16],
// Z[k] = (x[k] - x[k+16]) * W^k). Hand-computed values overwrite selected
// queue entries for the directed cases.
// ---------------------------------------------------------------------------
module tb_sdf_r2_stage_32;

    localparam int DW = 24;
    localparam int TW = 24;
    localparam int EW = 2 * DW + 1;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din_r = '0;
    logic [DW-1:0] din_i = '0;
    logic [1:0]    state = 2'd0;
    logic [TW-1:0] w_r = '0;
    logic [TW-1:0] w_i = '0;
    logic [DW-1:0] dout_r;
    logic [DW-1:0] dout_i;
    logic          dout_valid;
    logic          dout_last;

    always #5 clk = ~clk;

    sdf_r2_stage_32 #(.DW(DW), .TW(TW), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .din_r      (din_r),
        .din_i      (din_i),
        .state      (state),
        .w_r        (w_r),
        .w_i        (w_i),
        .dout_r     (dout_r),
        .dout_i     (dout_i),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
    );

    // ------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    bit mon_en     = 1'b0;
    bit gap_watch  = 1'b0;
    bit seen_valid = 1'b0;
    int gap_cnt    = 0;
    int out_seen   = 0;

    // W^k = exp(-j*2*pi*k/32) in Q8, rounded to nearest.
    int tw_r_tab[16] = '{256, 251, 237, 213, 181, 142, 98, 50,
                         0, -50, -98, -142, -181, -213, -237, -251};
    int tw_i_tab[16] = '{0, -50, -98, -142, -181, -213, -237, -251,
                         -256, -251, -237, -213, -181, -142, -98, -50};

    logic [DW-1:0] fr_r [4][32];
    logic [DW-1:0] fr_i [4][32];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [EW-1:0] act,
                         input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mul_re(input logic [DW-1:0] ar, ai,
                                             input logic [TW-1:0] wr, wi);
        longint p;
        p = longint'($signed(ar)) * longint'($signed(wr))
          - longint'($signed(ai)) * longint'($signed(wi));
        return DW'(p >>> 8);
    endfunction

    function automatic logic [DW-1:0] mul_im(input logic [DW-1:0] ar, ai,
                                             input logic [TW-1:0] wr, wi);
        longint p;
        p = longint'($signed(ar)) * longint'($signed(wi))
          + longint'($signed(ai)) * longint'($signed(wr));
        return DW'(p >>> 8);
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_valid === 1'b1) begin
                out_seen++;
                seen_valid = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h/%h expected=none (t=%0t)",
                             dout_r, dout_i, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("output", {dout_last, dout_r, dout_i}, mon_e);
                end
            end else begin
                if (dout_last !== 1'b0) begin
                    checks++;
                    failures++;
                    $display("FAIL last_without_valid actual=%b expected=0 (t=%0t)",
                             dout_last, $time);
                end
                if (gap_watch && seen_valid && exp_q.size() > 0) begin
                    gap_cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive(input logic [1:0] st, input logic v,
                         input logic [DW-1:0] r, input logic [DW-1:0] i,
                         input logic [TW-1:0] wr, input logic [TW-1:0] wi);
        state    = st;
        in_valid = v;
        din_r    = r;
        din_i    = i;
        w_r      = wr;
        w_i      = wi;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'd0, 1'b0, '0, '0, '0, '0);
    endtask

    // Reset with random inputs; all outputs must read zero afterwards.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         DW'($urandom), DW'($urandom), TW'($urandom), TW'($urandom));
        check("rst_dout_r",     EW'(dout_r),     '0);
        check("rst_dout_i",     EW'(dout_i),     '0);
        check("rst_dout_valid", EW'(dout_valid), '0);
        check("rst_dout_last",  EW'(dout_last),  '0);
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // Queue the model outputs of frames 0..nf-1, first `stop` entries only.
    task automatic push_model(input int nf, input int stop);
        logic [DW-1:0] dr, di, er, ei;
        bit last;
        for (int f = 0; f < nf; f++) begin
            for (int j = 0; j < 32; j++) begin
                if (f * 32 + j < stop) begin
                    if (j < 16) begin
                        er = fr_r[f][j] + fr_r[f][j+16];
                        ei = fr_i[f][j] + fr_i[f][j+16];
                    end else begin
                        dr = fr_r[f][j-16] - fr_r[f][j];
                        di = fr_i[f][j-16] - fr_i[f][j];
                        er = mul_re(dr, di, TW'(tw_r_tab[j-16]), TW'(tw_i_tab[j-16]));
                        ei = mul_im(dr, di, TW'(tw_r_tab[j-16]), TW'(tw_i_tab[j-16]));
                    end
                    last = (j == 31);
                    exp_q.push_back({last, er, ei});
                end
            end
        end
    endtask

    // Fill, then back-to-back add/multiply phases; stops after `stop`
    // add/multiply cycles.
    task automatic run_frames(input int nf, input int stop);
        int issued;
        logic [DW-1:0] nr, ni;
        issued = 0;
        for (int k = 0; k < 16; k++) drive(2'd0, 1'b1, fr_r[0][k], fr_i[0][k], '0, '0);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < 16; k++) begin
                if (issued >= stop) return;
                drive(2'd1, 1'b1, fr_r[f][16+k], fr_i[f][16+k], '0, '0);
                issued++;
            end
            for (int k = 0; k < 16; k++) begin
                if (issued >= stop) return;
                nr = (f + 1 < nf) ? fr_r[f+1][k] : '0;
                ni = (f + 1 < nf) ? fr_i[f+1][k] : '0;
                drive(2'd2, 1'b1, nr, ni, TW'(tw_r_tab[k]), TW'(tw_i_tab[k]));
                issued++;
            end
        end
    endtask

    // Let outstanding outputs appear, then require an empty queue.
    task automatic drain;
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) idle(1);
        idle(2);
        check("queue_drained", EW'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    task automatic clear_frames;
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 32; k++) begin
                fr_r[f][k] = '0;
                fr_i[f][k] = '0;
            end
    endtask

    task automatic rand_frames;
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 32; k++) begin
                fr_r[f][k] = DW'($urandom);
                fr_i[f][k] = DW'($urandom);
            end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        @(posedge clk);
        #1;

        // Reset with random inputs, then 15 fills must not produce output.
        do_reset(3);
        for (int k = 0; k < 15; k++) drive(2'd0, 1'b1, DW'($urandom), DW'($urandom), '0, '0);
        check("no_valid_after_15_fills", EW'(dout_valid), '0);
        idle(2);

        // Step in the first half.
        do_reset(1);
        clear_frames();
        for (int k = 0; k < 16; k++) fr_r[0][k] = 24'd256;
        push_model(1, 32);
        exp_q[16] = {1'b0, 24'd256,     24'd0};       // k=0  (256, 0)
        exp_q[20] = {1'b0, 24'd181,     24'hFFFF4B};  // k=4  (181, -181)
        exp_q[24] = {1'b0, 24'd0,       24'hFFFF00};  // k=8  (0, -256)
        exp_q[31] = {1'b1, 24'hFFFF05, 24'hFFFFCE};   // k=15 (-251, -50)
        for (int k = 0; k < 16; k++) exp_q[k] = {1'b0, 24'd256, 24'd0};
        run_frames(1, 32);
        drain();

        // Impulse in the second half.
        do_reset(1);
        clear_frames();
        for (int k = 16; k < 32; k++) begin
            fr_r[0][k] = 24'd100;
            fr_i[0][k] = 24'hFFFFF9;                  // -7
        end
        push_model(1, 32);
        for (int k = 0; k < 16; k++) exp_q[k] = {1'b0, 24'd100, 24'hFFFFF9};
        exp_q[16] = {1'b0, 24'hFFFF9C, 24'd7};        // k=0 (-100, 7)
        exp_q[24] = {1'b0, 24'd7,      24'd100};      // k=8 (7, 100)
        run_frames(1, 32);
        drain();

        // Modular wrap on the add path.
        do_reset(1);
        clear_frames();
        fr_r[0][0]  = 24'h7FFFFF;
        fr_i[0][0]  = 24'h800000;
        fr_r[0][16] = 24'h7FFFFF;
        fr_i[0][16] = 24'h800000;
        push_model(1, 32);
        exp_q[0] = {1'b0, 24'hFFFFFE, 24'h000000};
        run_frames(1, 32);
        drain();

        // Four continuous random frames.
        do_reset(1);
        rand_frames();
        push_model(4, 128);
        gap_cnt    = 0;
        seen_valid = 1'b0;
        out_seen   = 0;
        gap_watch  = 1'b1;
        run_frames(4, 128);
        drain();
        gap_watch = 1'b0;
        check("continuous_no_gap", EW'(gap_cnt), '0);
        check("continuous_count",  EW'(out_seen), EW'(128));

        // Reset after output 20, then a fresh frame with zero history.
        do_reset(1);
        rand_frames();
        push_model(1, 20);
        run_frames(1, 20);
        do_reset(1);
        check("mid_reset_queue_empty", EW'(exp_q.size()), '0);
        rand_frames();
        push_model(1, 32);
        out_seen = 0;
        run_frames(1, 32);
        drain();
        check("post_reset_count", EW'(out_seen), EW'(32));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdf_r2_stage_32.md
# sdf_r2_stage_32

Radix-2 single-path delay-feedback (SDF) butterfly stage with a 16-deep feedback delay, i.e. one 32-point-span stage of the pipelined FFT. It consumes the phase indicator `state` and Q8 twiddle pair `w_r`/`w_i` produced cycle-by-cycle by the 16-entry twiddle ROM sharing its `in_valid`. It performs the fill, butterfly-add and twiddle-multiply phases, and emits a framed output stream to the next stage.

## Interface
- `DW`, 24: complex sample component width (signed two's complement).
- `TW`, 24: twiddle component width (signed, Q8: 256 = 1.0).
- `DEPTH`, 16: feedback delay length (butterfly span / 2).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `din_r`/`din_i` carry a new sample (same signal that drives the twiddle ROM).
- `din_r`, `din_i` input DW: input sample, real/imag.
- `state` input 2: phase from the twiddle ROM (0 fill, 1 butterfly-add, 2 twiddle-multiply; 3 treated as 0).
- `w_r`, `w_i` input TW: twiddle for the current cycle, valid when `state`=2.
- `dout_r`, `dout_i` output DW: registered output sample.
- `dout_valid` output 1: `dout_r`/`dout_i` valid.
- `dout_last` output 1: high with the 32nd output of each frame.

## Operation
- Delay line: DEPTH complex registers, FIFO order. `head` = oldest entry. A push shifts in one value and drops `head`.
- Shift enable: `state`=0 → push only when `in_valid`=1. `state`=1/2 → push every cycle (the ROM advances every cycle in these phases).
- `state`=0 (fill): push (`din_r`,`din_i`). `dout_valid`<=0.
- `state`=1 (add): a=`head`, b=`din`. Output a+b. Push a−b.
- `state`=2 (multiply): output `head`×(`w_r`+j`w_i`). Push `din`. This pre-fills the first half of the next frame.
- Add/sub: DW-bit modular, no saturation, no growth bit. Scaling is owned by the surrounding pipeline.
- Multiply:
  - pr = a_r·w_r − a_i·w_i; pi = a_r·w_i + a_i·w_r.
  - Full DW+TW-bit signed products and sum.
  - Arithmetic shift right by 8, then keep the low DW bits (truncation toward −∞, modular wrap).
- Output counter: 5-bit, increments on every cycle with `dout_valid`=1 and wraps 31→0. `dout_last` = `dout_valid` && counter==31.
- Output order per frame: 16 sums X_even-path (k=0..15), then 16 twiddled differences (k=0..15).

## Timing
- Reset (`rst`=1 at a rising edge), all of the following cleared on that edge:
  - `dout_r`/`dout_i` = 0.
  - `dout_valid` = 0, `dout_last` = 0.
  - Delay line and output counter = 0.
- Reset has priority over every other input. Reset mid-frame discards all partial data. The ROM is reset by the same system, so phases restart at fill.
- Latency: the operation selected in cycle t appears on the outputs at edge t+1 (one register stage). The delay-line push takes effect on the same edge.
- `dout_valid` at t+1 equals (`state`∈{1,2}) at t.
- First frame: `dout_valid` first rises the cycle after `state` first becomes 1. Exactly 16 `in_valid` fill cycles are required beforehand.
- Back-to-back frames: `state` alternates 1/2 every 16 cycles with no bubble, giving `dout_valid` continuously high. `dout_last` repeats every 32 cycles.
- `in_valid`=0 during `state`=1/2 is not supported. The stage still consumes `din` (mirrors the ROM behaviour).
- `state` 1→2 and 2→1 switch mid-stream with no idle cycle. The head entry at the first `state`=2 cycle is the a−b pushed 16 cycles earlier.

## Test plan
- Reset: assert `rst` 3 cycles with random inputs → `dout_r`=`dout_i`=0, `dout_valid`=0, `dout_last`=0. A following fill of 15 samples gives no `dout_valid`.
- Step half: x[0..15]=(256,0), x[16..31]=(0,0), ROM twiddles → 16 outputs (256,0), then differences (256,0)·W^k. Check k=0 → (256,0), k=4 → (181,−181), k=8 → (0,−256), k=15 → (−251,−50).
- Second-half impulse: x[0..15]=0, x[16..31]=(100,−7) → 16 outputs (100,−7), then k=0 output (−100,7), k=8 output (7,100).
- Wrap: x[0]=x[16]=(0x7FFFFF,0x800000) → first sum output (0xFFFFFE,0x000000). `dout_last` is low on that output.
- Continuous 4 frames of random data vs. bit-exact reference model → all 128 outputs match, `dout_valid` never drops after the first rise, `dout_last` on outputs 31/63/95/127 only.
- Reset at output 20 of frame 1, then a fresh fill and frame → no output until 16 new fills. The new frame's outputs match the model with zero history, and the counter restarts (`dout_last` on the 32nd post-reset output).
